// File: rtl/sata_oob_pkg.sv
// Shared types and constants for the SATA host OOB / link bring-up controller.
// Build option OOB_AUTO_RETRY_EN enables timeout retries in sata_oob_ctrl.
package sata_oob_pkg;

  localparam int TMO_W = 20;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    SEND_COMINIT = 4'd1,
    WAIT_COMINIT = 4'd2,
    SEND_COMWAKE = 4'd3,
    WAIT_COMWAKE = 4'd4,
    WAIT_RXACT   = 4'd5,
    SEND_D102    = 4'd6,
    SEND_ALIGN   = 4'd7,
    READY        = 4'd8,
    ERROR        = 4'd9
  } oob_state_e;

  // Primitives are stored as 32-bit dwords; the low half goes on the wire first.
  localparam logic [31:0] ALIGN_PRIM = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_PRIM  = 32'hB5B5957C;
  localparam logic [15:0] D102_WORD  = 16'h4A4A;

  // Returns {charisk, data} for one half of a primitive: phase 0 = K half.
  function automatic logic [17:0] prim_word(input logic [31:0] prim, input logic phase);
    if (phase) begin
      return {2'b00, prim[31:16]};
    end
    return {2'b01, prim[15:0]};
  endfunction

endpackage

// File: rtl/sata_prim_det.sv
// Two-word primitive matcher: K-flagged low half followed by the plain high half.
// det pulses combinationally while the second word is on rxdata.
module sata_prim_det
  import sata_oob_pkg::*;
#(
  parameter logic [31:0] PRIM = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] rxdata,
  input  logic [1:0]  rxcharisk,
  output logic        det
);

  logic cand_q;
  logic cand_d;

  always_comb begin
    cand_d = (rxcharisk == 2'b01) && (rxdata == PRIM[15:0]);
    det    = cand_q && (rxcharisk == 2'b00) && (rxdata == PRIM[31:16]);
  end

  // A candidate lives for exactly one cycle, so any other second word discards it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q <= 1'b0;
    end else begin
      cand_q <= cand_d;
    end
  end

endmodule

// File: rtl/sata_oob_ctrl.sv
// Host-side SATA OOB sequencer: COMINIT, COMWAKE, D10.2, ALIGN, SYNC, then link_up.
// Define OOB_AUTO_RETRY_EN to retry from COMINIT on timeout up to RETRY_MAX times.
module sata_oob_ctrl
  import sata_oob_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYC = 20'd66000
`ifdef OOB_AUTO_RETRY_EN
  , parameter logic [3:0] RETRY_MAX = 4'd15
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [15:0] txdata,
  output logic [1:0]  txcharisk,
  output logic        txelecidle,
  output logic        txcominit,
  output logic        txcomwake,
  input  logic        txcomfinish,
  input  logic        rxcominitdet,
  input  logic        rxcomwakedet,
  input  logic        rxelecidle,
  input  logic        rxbyteisaligned,
  input  logic [15:0] rxdata,
  input  logic [1:0]  rxcharisk,
  output logic        link_up,
  output logic [3:0]  state,
  output logic        error
);

  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT_CYC - TMO_W'(1);

  oob_state_e       state_q, state_d, adv_state;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             phase_q, phase_d;
  logic [15:0]      txdata_q, txdata_d;
  logic [1:0]       txcharisk_q, txcharisk_d;
  logic             txelecidle_q, txelecidle_d;
  logic             txcominit_q, txcominit_d;
  logic             txcomwake_q, txcomwake_d;
  logic             link_up_q, link_up_d;
  logic             error_q, error_d;
  logic             align_det, sync_det;
  logic             adv, enter, counting, tmo_evt;
`ifdef OOB_AUTO_RETRY_EN
  logic [3:0]       retry_q, retry_d;
`endif

  sata_prim_det #(.PRIM(ALIGN_PRIM)) u_align_det (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxdata    (rxdata),
    .rxcharisk (rxcharisk),
    .det       (align_det)
  );

  sata_prim_det #(.PRIM(SYNC_PRIM)) u_sync_det (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxdata    (rxdata),
    .rxcharisk (rxcharisk),
    .det       (sync_det)
  );

  // Forward progress condition for each state, independent of start and timeout.
  always_comb begin
    adv       = 1'b0;
    adv_state = state_q;
    case (state_q)
      IDLE:         begin adv = start;                         adv_state = SEND_COMINIT; end
      SEND_COMINIT: begin adv = txcomfinish;                   adv_state = WAIT_COMINIT; end
      WAIT_COMINIT: begin adv = rxcominitdet;                  adv_state = SEND_COMWAKE; end
      SEND_COMWAKE: begin adv = txcomfinish;                   adv_state = WAIT_COMWAKE; end
      WAIT_COMWAKE: begin adv = rxcomwakedet;                  adv_state = WAIT_RXACT;   end
      WAIT_RXACT:   begin adv = !rxelecidle;                   adv_state = SEND_D102;    end
      SEND_D102:    begin adv = align_det && rxbyteisaligned;  adv_state = SEND_ALIGN;   end
      SEND_ALIGN:   begin adv = sync_det;                      adv_state = READY;        end
      READY:        begin adv = rxcominitdet;                  adv_state = SEND_COMINIT; end
      ERROR:        begin adv = 1'b0;                          adv_state = ERROR;        end
      default:      begin adv = 1'b1;                          adv_state = IDLE;         end
    endcase
  end

  always_comb begin
    counting = !(state_q inside {IDLE, READY, ERROR});
    tmo_evt  = counting && (tmo_cnt_q == TMO_LAST);
    state_d  = state_q;
    enter    = 1'b0;
`ifdef OOB_AUTO_RETRY_EN
    retry_d  = retry_q;
`endif

    // Priority: start drop, then detects, then timeout.
    if (state_q != IDLE && !start) begin
      state_d = IDLE;
      enter   = 1'b1;
    end else if (adv) begin
      state_d = adv_state;
      enter   = 1'b1;
    end else if (tmo_evt) begin
      enter = 1'b1;
`ifdef OOB_AUTO_RETRY_EN
      if (retry_q == RETRY_MAX) begin
        state_d = ERROR;
      end else begin
        state_d = SEND_COMINIT;
        retry_d = retry_q + 4'd1;
      end
`else
      state_d = ERROR;
`endif
    end

`ifdef OOB_AUTO_RETRY_EN
    if (state_d == IDLE || (enter && state_d == READY)) begin
      retry_d = 4'd0;
    end
`endif

    if (enter) begin
      tmo_cnt_d = '0;
    end else if (counting && tmo_cnt_q != TMO_LAST) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end

    phase_d = enter ? 1'b0 : !phase_q;

    // Outputs are computed for the state being entered so they register with it.
    txelecidle_d = 1'b1;
    txdata_d     = 16'h0000;
    txcharisk_d  = 2'b00;
    case (state_d)
      SEND_D102: begin
        txelecidle_d = 1'b0;
        txdata_d     = D102_WORD;
      end
      SEND_ALIGN: begin
        txelecidle_d              = 1'b0;
        {txcharisk_d, txdata_d}   = prim_word(ALIGN_PRIM, phase_d);
      end
      READY: begin
        txelecidle_d              = 1'b0;
        {txcharisk_d, txdata_d}   = prim_word(SYNC_PRIM, phase_d);
      end
      default: begin
        txelecidle_d = 1'b1;
      end
    endcase

    txcominit_d = enter && (state_d == SEND_COMINIT);
    txcomwake_d = enter && (state_d == SEND_COMWAKE);
    link_up_d   = (state_d == READY);
    error_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tmo_cnt_q    <= '0;
      phase_q      <= 1'b0;
      txdata_q     <= 16'h0000;
      txcharisk_q  <= 2'b00;
      txelecidle_q <= 1'b1;
      txcominit_q  <= 1'b0;
      txcomwake_q  <= 1'b0;
      link_up_q    <= 1'b0;
      error_q      <= 1'b0;
`ifdef OOB_AUTO_RETRY_EN
      retry_q      <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      phase_q      <= phase_d;
      txdata_q     <= txdata_d;
      txcharisk_q  <= txcharisk_d;
      txelecidle_q <= txelecidle_d;
      txcominit_q  <= txcominit_d;
      txcomwake_q  <= txcomwake_d;
      link_up_q    <= link_up_d;
      error_q      <= error_d;
`ifdef OOB_AUTO_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign state      = state_q;
  assign txdata     = txdata_q;
  assign txcharisk  = txcharisk_q;
  assign txelecidle = txelecidle_q;
  assign txcominit  = txcominit_q;
  assign txcomwake  = txcomwake_q;
  assign link_up    = link_up_q;
  assign error      = error_q;

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// Randomized bring-up bench for sata_oob_ctrl: state-sequence scoreboard plus
// per-cycle output model derived from the state-by-state output table.
module tb_sata_oob_ctrl;

  localparam logic [19:0] TMO     = 20'd100;
  localparam int          TMO_INT = 100;
`ifdef OOB_AUTO_RETRY_EN
  localparam logic [3:0]  RMAX    = 4'd2;
`endif

  localparam logic [3:0] S_IDLE         = 4'd0;
  localparam logic [3:0] S_SEND_COMINIT = 4'd1;
  localparam logic [3:0] S_WAIT_COMINIT = 4'd2;
  localparam logic [3:0] S_SEND_COMWAKE = 4'd3;
  localparam logic [3:0] S_WAIT_COMWAKE = 4'd4;
  localparam logic [3:0] S_WAIT_RXACT   = 4'd5;
  localparam logic [3:0] S_SEND_D102    = 4'd6;
  localparam logic [3:0] S_SEND_ALIGN   = 4'd7;
  localparam logic [3:0] S_READY        = 4'd8;
  localparam logic [3:0] S_ERROR        = 4'd9;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        txcomfinish = 1'b0;
  logic        rxcominitdet = 1'b0;
  logic        rxcomwakedet = 1'b0;
  logic        rxelecidle = 1'b1;
  logic        rxbyteisaligned = 1'b0;
  logic [15:0] rxdata = 16'h0;
  logic [1:0]  rxcharisk = 2'b00;
  logic [15:0] txdata;
  logic [1:0]  txcharisk;
  logic        txelecidle, txcominit, txcomwake, link_up, error;
  logic [3:0]  state;

  int checks = 0;
  int failures = 0;
  int cominit_cnt = 0;
  logic [3:0] exp_q[$];

  sata_oob_ctrl #(
    .TIMEOUT_CYC(TMO)
`ifdef OOB_AUTO_RETRY_EN
    , .RETRY_MAX(RMAX)
`endif
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .txdata          (txdata),
    .txcharisk       (txcharisk),
    .txelecidle      (txelecidle),
    .txcominit       (txcominit),
    .txcomwake       (txcomwake),
    .txcomfinish     (txcomfinish),
    .rxcominitdet    (rxcominitdet),
    .rxcomwakedet    (rxcomwakedet),
    .rxelecidle      (rxelecidle),
    .rxbyteisaligned (rxbyteisaligned),
    .rxdata          (rxdata),
    .rxcharisk       (rxcharisk),
    .link_up         (link_up),
    .state           (state),
    .error           (error)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected {txdata, txcharisk, txelecidle, txcominit, txcomwake, link_up, error}
  // given the state and the number of cycles spent in it.
  function automatic logic [22:0] exp_out(input logic [3:0] st, input int cyc);
    logic [15:0] d;
    logic [1:0]  k;
    logic        ei;
    d  = 16'h0;
    k  = 2'b00;
    ei = 1'b1;
    case (st)
      S_SEND_D102: begin d = 16'h4A4A; ei = 1'b0; end
      S_SEND_ALIGN: begin
        ei = 1'b0;
        if (cyc % 2 == 0) begin d = 16'h4ABC; k = 2'b01; end
        else d = 16'h7B4A;
      end
      S_READY: begin
        ei = 1'b0;
        if (cyc % 2 == 0) begin d = 16'h957C; k = 2'b01; end
        else d = 16'hB5B5;
      end
      default: ei = 1'b1;
    endcase
    return {d, k, ei, (st == S_SEND_COMINIT) && (cyc % TMO_INT == 0),
            (st == S_SEND_COMWAKE) && (cyc == 0), st == S_READY, st == S_ERROR};
  endfunction

  // scoreboard monitor
  initial begin : monitor
    logic [3:0] prev_st;
    logic [3:0] e;
    int cyc;
    prev_st = S_IDLE;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (state !== prev_st) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL state_unexpected actual=%0h required=%0h", state, prev_st);
        end else begin
          e = exp_q.pop_front();
          check("state_seq", state, e);
        end
        prev_st = state;
        cyc = 0;
      end
      check("outputs", {txdata, txcharisk, txelecidle, txcominit, txcomwake, link_up, error},
            exp_out(state, cyc));
      if (txcominit) cominit_cnt++;
      cyc++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    rxdata    = 16'($urandom_range(0, 65535));
    rxcharisk = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      noise();
      tick();
    end
  endtask

  function automatic int dly();
    return int'($urandom_range(1, 12));
  endfunction

  task automatic fire(input string name, input logic [3:0] nxt);
    exp_q.push_back(nxt);
    tick();
    check(name, state, nxt);
  endtask

  task automatic send_word(input logic [15:0] d, input logic [1:0] k);
    rxdata    = d;
    rxcharisk = k;
    tick();
  endtask

  task automatic to_d102();
    rxelecidle      = 1'b1;
    rxbyteisaligned = 1'b0;
    idle(dly()); txcomfinish  = 1'b1; fire("comfinish_init", S_WAIT_COMINIT); txcomfinish  = 1'b0;
    idle(dly()); rxcominitdet = 1'b1; fire("cominit_det", S_SEND_COMWAKE);    rxcominitdet = 1'b0;
    idle(dly()); txcomfinish  = 1'b1; fire("comfinish_wake", S_WAIT_COMWAKE); txcomfinish  = 1'b0;
    idle(dly()); rxcomwakedet = 1'b1; fire("comwake_det", S_WAIT_RXACT);      rxcomwakedet = 1'b0;
    idle(dly()); rxelecidle   = 1'b0; fire("rx_active", S_SEND_D102);
    idle(dly());
  endtask

  task automatic align_step(input bit force_bad);
    if (force_bad || $urandom_range(0, 1) == 1) begin
      rxbyteisaligned = 1'b1;
      send_word(16'h4ABC, 2'b01);
      send_word(16'h7B4B, 2'b00);
      check("corrupt_align", state, S_SEND_D102);
    end
    if ($urandom_range(0, 1) == 1) begin
      rxbyteisaligned = 1'b0;
      send_word(16'h4ABC, 2'b01);
      send_word(16'h7B4A, 2'b00);
      check("unaligned_align", state, S_SEND_D102);
    end
    idle(dly());
    rxbyteisaligned = 1'b1;
    send_word(16'h4ABC, 2'b01);
    rxdata    = 16'h7B4A;
    rxcharisk = 2'b00;
    fire("align_det", S_SEND_ALIGN);
  endtask

  task automatic finish_sync();
    idle(dly());
    send_word(16'h957C, 2'b01);
    rxdata    = 16'hB5B5;
    rxcharisk = 2'b00;
    fire("sync_det", S_READY);
    idle(int'($urandom_range(4, 10)));
  endtask

  initial begin : driver
    int n;
    #1 reset_n = 1'b0;
    #2;
    check("reset_outputs", {txdata, txcharisk, txelecidle, txcominit, txcomwake, link_up, error},
          {16'h0, 2'b00, 1'b1, 4'b0000});
    check("reset_state", state, S_IDLE);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // normal bring-up, optional device-initiated COMINIT from READY
    for (int it = 0; it < 6; it++) begin
      start = 1'b1;
      fire("start", S_SEND_COMINIT);
      to_d102();
      align_step(it == 0);
      finish_sync();
      if (it == 0 || $urandom_range(0, 1) == 1) begin
        rxcominitdet = 1'b1;
        fire("device_reset", S_SEND_COMINIT);
        rxcominitdet = 1'b0;
        check("device_reset_link", link_up, 1'b0);
        to_d102();
        align_step(1'b0);
        finish_sync();
      end
      start = 1'b0;
      fire("stop", S_IDLE);
      idle(2);
    end

    // start=0 wins over a same-cycle ALIGN detect
    start = 1'b1;
    fire("start_p", S_SEND_COMINIT);
    to_d102();
    rxbyteisaligned = 1'b1;
    send_word(16'h4ABC, 2'b01);
    rxdata    = 16'h7B4A;
    rxcharisk = 2'b00;
    start     = 1'b0;
    fire("stop_beats_detect", S_IDLE);
    idle(2);

    // detect on the last cycle before timeout wins
    rxelecidle = 1'b1;
    start = 1'b1;
    fire("start_t", S_SEND_COMINIT);
    idle(3);
    txcomfinish = 1'b1; fire("comfinish_t", S_WAIT_COMINIT); txcomfinish = 1'b0;
    idle(TMO_INT - 1);
    rxcominitdet = 1'b1; fire("detect_beats_timeout", S_SEND_COMWAKE); rxcominitdet = 1'b0;
    start = 1'b0;
    fire("stop_t", S_IDLE);
    idle(2);

    // silent device: timeout path
`ifdef OOB_AUTO_RETRY_EN
    cominit_cnt = 0;
    start = 1'b1;
    fire("start_r", S_SEND_COMINIT);
    exp_q.push_back(S_ERROR);
    n = 0;
    while (state != S_ERROR && n < 2000) begin noise(); tick(); n++; end
    check("retry_cycles", n, (int'(RMAX) + 1) * TMO_INT);
    check("retry_cominit_pulses", cominit_cnt, int'(RMAX) + 1);
`else
    start = 1'b1;
    fire("start_e", S_SEND_COMINIT);
    idle(2);
    txcomfinish = 1'b1; fire("comfinish_e", S_WAIT_COMINIT); txcomfinish = 1'b0;
    exp_q.push_back(S_ERROR);
    n = 0;
    while (state != S_ERROR && n < 1000) begin noise(); tick(); n++; end
    check("timeout_cycles", n, TMO_INT);
`endif
    check("error_flag", error, 1'b1);
    check("error_elecidle", txelecidle, 1'b1);
    idle(5);
    check("error_held", state, S_ERROR);
    start = 1'b0;
    fire("error_exit", S_IDLE);
    check("error_clear", error, 1'b0);
    idle(2);

    // async reset while transmitting ALIGN
    start = 1'b1;
    fire("start_a", S_SEND_COMINIT);
    to_d102();
    align_step(1'b0);
    idle(2);
    exp_q.push_back(S_IDLE);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_out", {txdata, txcharisk, txelecidle, txcominit, txcomwake, link_up, error},
          {16'h0, 2'b00, 1'b1, 4'b0000});
    check("async_rst_state", state, S_IDLE);
    start = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    idle(3);
    check("post_rst_idle", state, S_IDLE);

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
